// File: rtl/drive_sequencer.sv
// Supervisory drive sequencer: arbitrates cruise, obstacle avoidance and tilt
// emergency, and produces ramped ESC and steering pulse-width commands.
module drive_sequencer #(
    parameter int TICK_DIV     = 50000,
    parameter int SPEED_NORMAL = 2000,
    parameter int SPEED_LOW    = 0,
    parameter int RAMP_STEP    = 50,
    parameter int ANGLE_CENTER = 1500,
    parameter int ANGLE_AVOID  = 1000,
    parameter int DIST_MIN     = 5,
    parameter int DIST_NEAR    = 60,
    parameter int DIST_CLEAR   = 80,
    parameter int TILT_LIMIT   = 10000,
    parameter int AVOID_TICKS  = 500,
    parameter int CALM_TICKS   = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  distance,
    input  logic [9:0]  speed,
    input  logic [15:0] triangle,
    output logic [15:0] speed_control,
    output logic [15:0] angle_control,
    output logic        led1,
    output logic        led2,
    output logic        voice,
    output logic [1:0]  state,
    output logic [9:0]  speed_q
);

    typedef enum logic [1:0] {
        DRIVE     = 2'd0,
        AVOID     = 2'd1,
        EMERGENCY = 2'd2,
        RECOVER   = 2'd3
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]       PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [15:0]         SPD_NORM  = 16'(SPEED_NORMAL);
    localparam logic [15:0]         SPD_LOW   = 16'(SPEED_LOW);
    localparam logic [15:0]         STEP      = 16'(RAMP_STEP);
    localparam logic [15:0]         ANG_CTR   = 16'(ANGLE_CENTER);
    localparam logic [15:0]         ANG_AVD   = 16'(ANGLE_AVOID);
    localparam logic [9:0]          D_MIN     = 10'(DIST_MIN);
    localparam logic [9:0]          D_NEAR    = 10'(DIST_NEAR);
    localparam logic [9:0]          D_CLEAR   = 10'(DIST_CLEAR);
    localparam logic signed [15:0]  TILT_V    = 16'(TILT_LIMIT);
    localparam logic [15:0]         AVT       = 16'(AVOID_TICKS);
    localparam logic [15:0]         CALT      = 16'(CALM_TICKS);

    logic [9:0]    dist_q;
    logic [15:0]   tri_q;
    logic [9:0]    speed_q_reg;
    logic [PW-1:0] presc_reg;
    logic [15:0]   timer_reg;
    state_t        state_reg, state_next;
    logic [15:0]   speed_reg, angle_reg;
    logic          led1_reg, led2_reg, voice_reg;

    logic          tilt, near, clear, tick;
    logic [15:0]   target, ramp_next;

    assign tilt = $signed(tri_q) > TILT_V;
    assign near = (dist_q >= D_MIN) && (dist_q <= D_NEAR);
    assign clear = dist_q > D_CLEAR;
    assign tick = presc_reg == PRESC_MAX;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DRIVE: begin
                if (tilt)      state_next = EMERGENCY;
                else if (near) state_next = AVOID;
            end
            AVOID: begin
                if (tilt)                             state_next = EMERGENCY;
                else if (timer_reg >= AVT && clear)   state_next = RECOVER;
            end
            EMERGENCY: begin
                if (!tilt && timer_reg >= CALT)       state_next = RECOVER;
            end
            RECOVER: begin
                if (tilt)                             state_next = EMERGENCY;
                else if (near)                        state_next = AVOID;
                else if (speed_reg == SPD_NORM)       state_next = DRIVE;
            end
            default: state_next = RECOVER;
        endcase
    end

    // The ramp follows the state being entered, so a tick on a transition edge uses the new target.
    always_comb begin
        target = (state_next == DRIVE || state_next == RECOVER) ? SPD_NORM : SPD_LOW;
        ramp_next = speed_reg;
        if (speed_reg < target) begin
            ramp_next = (target - speed_reg <= STEP) ? target : speed_reg + STEP;
        end else if (speed_reg > target) begin
            ramp_next = (speed_reg - target <= STEP) ? target : speed_reg - STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dist_q      <= '0;
            tri_q       <= '0;
            speed_q_reg <= '0;
            presc_reg   <= '0;
            timer_reg   <= '0;
            state_reg   <= RECOVER;
            speed_reg   <= SPD_LOW;
            angle_reg   <= ANG_CTR;
            led1_reg    <= 1'b0;
            led2_reg    <= 1'b0;
            voice_reg   <= 1'b0;
        end else begin
            dist_q      <= distance;
            tri_q       <= triangle;
            speed_q_reg <= speed;
            presc_reg   <= tick ? '0 : presc_reg + PW'(1);
            state_reg   <= state_next;

            // Any tilt while in EMERGENCY restarts the calm period.
            if (state_next != state_reg || (state_reg == EMERGENCY && tilt)) begin
                timer_reg <= '0;
            end else if (tick && timer_reg != 16'hFFFF) begin
                timer_reg <= timer_reg + 16'd1;
            end

            if (state_next == EMERGENCY && state_reg != EMERGENCY) begin
                speed_reg <= SPD_LOW;
            end else if (tick) begin
                speed_reg <= ramp_next;
            end

            angle_reg <= (state_next == AVOID) ? ANG_AVD : ANG_CTR;
            led1_reg  <= state_next == AVOID;
            led2_reg  <= state_next == EMERGENCY;
            voice_reg <= (state_next == AVOID) || (state_next == EMERGENCY);
        end
    end

    assign speed_control = speed_reg;
    assign angle_control = angle_reg;
    assign led1          = led1_reg;
    assign led2          = led2_reg;
    assign voice         = voice_reg;
    assign state         = state_reg;
    assign speed_q       = speed_q_reg;

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer with a short tick; every expected value
// is hand-derived from edge counts after reset release.
module tb_drive_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  distance;
    logic [9:0]  speed;
    logic [15:0] triangle;
    logic [15:0] speed_control;
    logic [15:0] angle_control;
    logic        led1, led2, voice;
    logic [1:0]  state;
    logic [9:0]  speed_q;

    int checks = 0;
    int errors = 0;
    int e = 0;

    drive_sequencer #(
        .TICK_DIV    (4),
        .AVOID_TICKS (10),
        .CALM_TICKS  (20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .distance      (distance),
        .speed         (speed),
        .triangle      (triangle),
        .speed_control (speed_control),
        .angle_control (angle_control),
        .led1          (led1),
        .led2          (led2),
        .voice         (voice),
        .state         (state),
        .speed_q       (speed_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s @e%0d: got %0d want %0d", tag, e, obs, exp);
        end else begin
            $display("ok   %s @e%0d: %0d", tag, e, obs);
        end
    endtask

    // Advance to 1 time unit after edge t (edges counted from reset release).
    task automatic goto(input int t);
        while (e < t) begin
            @(posedge clk);
            #1;
            e++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, int'(state), 3);
        check({tag, "_speed"}, int'(speed_control), 0);
        check({tag, "_angle"}, int'(angle_control), 1500);
        check({tag, "_led1"}, int'(led1), 0);
        check({tag, "_led2"}, int'(led2), 0);
        check({tag, "_voice"}, int'(voice), 0);
        check({tag, "_speed_q"}, int'(speed_q), 0);
    endtask

    initial begin
        rst      = 1'b1;
        distance = 10'd200;
        speed    = 10'd123;
        triangle = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst_init");
        rst = 1'b0;
        e   = 0;

        goto(2);
        check("speed_q_pass", int'(speed_q), 123);
        check("start_state", int'(state), 3);

        // Ramp to cruise: one 50 step every 4th edge.
        for (int k = 1; k <= 40; k++) begin
            goto(4 * k);
            check("ramp_up", int'(speed_control), 50 * k);
            check("ramp_state", int'(state), 3);
        end
        goto(161);
        check("drive_state", int'(state), 0);
        check("drive_speed", int'(speed_control), 2000);
        check("drive_angle", int'(angle_control), 1500);
        check("drive_led1", int'(led1), 0);

        // Boundary distances that must not trigger avoidance.
        distance = 10'd61;
        goto(163);
        check("dist61_state", int'(state), 0);
        distance = 10'd4;
        goto(165);
        check("dist4_state", int'(state), 0);
        distance = 10'd60;
        goto(166);
        check("near_latency", int'(state), 0);
        goto(167);
        check("avoid_state", int'(state), 1);
        check("avoid_angle", int'(angle_control), 1000);
        check("avoid_led1", int'(led1), 1);
        check("avoid_voice", int'(voice), 1);
        check("avoid_led2", int'(led2), 0);
        check("avoid_speed0", int'(speed_control), 2000);
        goto(168);
        check("ramp_dn1", int'(speed_control), 1950);
        goto(169);
        distance = 10'd81;
        goto(172);
        check("ramp_dn2", int'(speed_control), 1900);
        goto(184);
        check("clear_early", int'(state), 1);
        distance = 10'd60;
        goto(205);
        distance = 10'd70;
        goto(214);
        check("hyst_70", int'(state), 1);
        distance = 10'd81;
        goto(215);
        check("clear_latency", int'(state), 1);
        check("avoid_speed", int'(speed_control), 1400);
        goto(216);
        check("recover_state", int'(state), 3);
        check("recover_tick_speed", int'(speed_control), 1450);
        check("recover_angle", int'(angle_control), 1500);
        check("recover_led1", int'(led1), 0);
        check("recover_voice", int'(voice), 0);

        // Tilt exactly at the limit is not a tilt.
        goto(217);
        triangle = 16'd10000;
        goto(224);
        check("tilt_limit", int'(state), 3);
        check("tilt_limit_spd", int'(speed_control), 1550);
        goto(225);
        triangle = 16'd10001;
        goto(226);
        check("tilt_latency", int'(state), 3);
        check("tilt_latency_spd", int'(speed_control), 1550);
        goto(227);
        check("emerg_state", int'(state), 2);
        check("emerg_speed", int'(speed_control), 0);
        check("emerg_led2", int'(led2), 1);
        check("emerg_voice", int'(voice), 1);
        check("emerg_led1", int'(led1), 0);
        check("emerg_angle", int'(angle_control), 1500);
        triangle = 16'd0;

        goto(233);
        distance = 10'd30;
        goto(240);
        check("emerg_ignore_near", int'(state), 2);
        goto(288);
        triangle = 16'd12000;
        goto(289);
        triangle = 16'd0;
        goto(310);
        check("calm_restarted", int'(state), 2);
        goto(344);
        check("emerg_hold", int'(state), 2);
        distance = 10'd200;
        goto(368);
        check("calm_not_yet", int'(state), 2);
        goto(369);
        check("calm_exit", int'(state), 3);
        check("calm_exit_speed", int'(speed_control), 0);
        check("calm_exit_led2", int'(led2), 0);
        check("calm_exit_voice", int'(voice), 0);
        goto(372);
        check("recover_ramp", int'(speed_control), 50);

        // DIST_MIN itself counts as near.
        distance = 10'd5;
        goto(373);
        check("dist5_latency", int'(state), 3);
        goto(374);
        check("dist5_state", int'(state), 1);
        check("dist5_led1", int'(led1), 1);
        check("dist5_angle", int'(angle_control), 1000);
        goto(375);
        check("pre_rst_speed", int'(speed_control), 50);

        // Asynchronous reset mid-AVOID, sampled before the next clock edge.
        #1;
        rst = 1'b1;
        #2;
        check_reset_outputs("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_state", int'(state), 3);
        check("rst_hold_speed", int'(speed_control), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
